// File: rtl/seg7_display_sched_if.sv
// Source-side bundle for seg7_display_sched: per-source valid levels, packed
// 14-bit values and the one-hot capture acknowledge.
interface seg7_display_sched_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC*14-1:0] src_value;
  logic [NUM_SRC-1:0]    src_ack;

  modport master (output src_valid, output src_value, input src_ack);
  modport slave  (input src_valid, input src_value, output src_ack);
endinterface

// File: rtl/seg7_display_sched.sv
// Round-robin statistic source scheduler for a 4-digit seven-segment display with
// sequential double-dabble conversion. Optional macro SEG7_SRC_TAG_EN shows the source index on digit3.
module seg7_display_sched #(
  parameter int NUM_SRC     = 4,
  parameter int DWELL_WIDTH = 24,
  localparam int IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_display_sched_if.slave  src,
  input  logic                 freeze,
  output logic [IDX_W-1:0]     cur_src,
  output logic                 busy,
  output logic [4:0]           digit0,
  output logic [4:0]           digit1,
  output logic [4:0]           digit2,
  output logic [4:0]           digit3
);

  localparam logic [4:0] DASH = 5'h10;

  typedef enum logic [2:0] {IDLE, SELECT, CONVERT, UPDATE, DWELL} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       cur_src_q, cur_src_d;
  logic [3:0]             step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [13:0]            bin_q, bin_d;
  logic [19:0]            bcd_q, bcd_d;
  logic [3:0][4:0]        digits_q, digits_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  int                     cand;
  logic [NUM_SRC-1:0]     ack_c;
  logic [19:0]            bcd_adj;
  logic                   ovf;

  function automatic logic [19:0] dabble_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int n = 0; n < 5; n++) begin
      if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

  // First valid source strictly after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      cand = (int'(ptr_q) + i) % NUM_SRC;
      if (!win_found && src.src_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_src_d = cur_src_q;
    step_d    = step_q;
    dwell_d   = dwell_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    digits_d  = digits_q;
    ack_c     = '0;
    bcd_adj   = dabble_adjust(bcd_q);
`ifdef SEG7_SRC_TAG_EN
    ovf       = |bcd_q[19:12];
`else
    ovf       = |bcd_q[19:16];
`endif

    unique case (state_q)
      IDLE: begin
        if (|src.src_valid && !freeze) state_d = SELECT;
      end
      SELECT: begin
        if (win_found) begin
          ack_c[win_idx] = 1'b1;
          cur_src_d      = win_idx;
          ptr_d          = win_idx;
          bin_d          = src.src_value[14*int'(win_idx) +: 14];
          bcd_d          = '0;
          step_d         = '0;
          state_d        = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        bcd_d  = {bcd_adj[18:0], bin_q[13]};
        bin_d  = {bin_q[12:0], 1'b0};
        step_d = step_q + 4'd1;
        if (step_q == 4'd13) state_d = UPDATE;
      end
      UPDATE: begin
        for (int n = 0; n < 3; n++) begin
          digits_d[n] = ovf ? DASH : {1'b0, bcd_q[4*n +: 4]};
        end
`ifdef SEG7_SRC_TAG_EN
        digits_d[3] = {1'b0, 4'(cur_src_q)};
`else
        digits_d[3] = ovf ? DASH : {1'b0, bcd_q[15:12]};
`endif
        dwell_d = '0;
        state_d = DWELL;
      end
      DWELL: begin
        dwell_d = dwell_q + 1'b1;
        // While frozen the counter simply wraps and the display is held.
        if (dwell_q == {DWELL_WIDTH{1'b1}} && !freeze) begin
          state_d = (|src.src_valid) ? SELECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NUM_SRC - 1);
      cur_src_q <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      digits_q  <= {4{DASH}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_src_q <= cur_src_d;
      step_q    <= step_d;
      dwell_q   <= dwell_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      digits_q  <= digits_d;
    end
  end

  assign src.src_ack = ack_c;
  assign cur_src     = cur_src_q;
  assign busy        = (state_q == SELECT) || (state_q == CONVERT) || (state_q == UPDATE);
  assign digit0      = digits_q[0];
  assign digit1      = digits_q[1];
  assign digit2      = digits_q[2];
  assign digit3      = digits_q[3];

endmodule

// File: tb/tb_seg7_display_sched.sv
// Self-checking bench for seg7_display_sched: timeline model of the schedule plus
// directed checks of reset, boundaries, round-robin order, freeze and mid-conversion reset.
module tb_seg7_display_sched;

  localparam int NUM_SRC = 4;
  localparam int DW      = 4;
  localparam int PERIOD  = 16 + (1 << DW);

  logic       clk;
  logic       rst;
  logic       freeze;
  logic [1:0] cur_src;
  logic       busy;
  logic [4:0] digit0, digit1, digit2, digit3;

  seg7_display_sched_if #(.NUM_SRC(NUM_SRC)) bus ();

  seg7_display_sched #(.NUM_SRC(NUM_SRC), .DWELL_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .src     (bus),
    .freeze  (freeze),
    .cur_src (cur_src),
    .busy    (busy),
    .digit0  (digit0),
    .digit1  (digit1),
    .digit2  (digit2),
    .digit3  (digit3)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Display codes straight from decimal arithmetic: {digit3,digit2,digit1,digit0}.
  function automatic logic [19:0] modelDigits(input int v);
    logic [19:0] r;
`ifdef SEG7_SRC_TAG_EN
    if (v > 999) r = {5'h00, 5'h10, 5'h10, 5'h10};
    else r = {5'h00, 5'(v / 100 % 10), 5'(v / 10 % 10), 5'(v % 10)};
`else
    if (v > 9999) r = {4{5'h10}};
    else r = {5'(v / 1000 % 10), 5'(v / 100 % 10), 5'(v / 10 % 10), 5'(v % 10)};
`endif
    return r;
  endfunction

  function automatic logic [55:0] pack4(input int v0, input int v1, input int v2, input int v3);
    return {14'(v3), 14'(v2), 14'(v1), 14'(v0)};
  endfunction

  // Timeline model: absolute cycle numbers of the next selection, digit update and dwell expiry.
  int          m_ptr, m_cur, m_pend_cur, m_cur_at;
  int          m_sel_at, m_conv_from, m_upd_at, m_term_at;
  bit          m_idle;
  logic [19:0] m_dig, m_pend_dig;

  task automatic modelReset();
    m_ptr = NUM_SRC - 1; m_cur = 0; m_pend_cur = 0; m_cur_at = -1;
    m_sel_at = -1; m_conv_from = -1; m_upd_at = -1; m_term_at = -1;
    m_idle = 1'b1; m_dig = {4{5'h10}}; m_pend_dig = '0;
  endtask

  initial modelReset();

  always @(negedge clk) begin
    int          w;
    logic [3:0]  exp_ack;
    logic        exp_busy;
    w = -1;
    if (rst) begin
      modelReset();
      checkOutput("cmp_rst_ack", 32'(bus.src_ack), 32'h0);
      checkOutput("cmp_rst_busy", 32'(busy), 32'h0);
      checkOutput("cmp_rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'({4{5'h10}}));
    end else begin
      if (cyc == m_upd_at) m_dig = m_pend_dig;
      if (cyc == m_cur_at) m_cur = m_pend_cur;
      if (cyc == m_sel_at) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (w < 0 && bus.src_valid[(m_ptr + i) % NUM_SRC]) w = (m_ptr + i) % NUM_SRC;
        end
      end
      exp_ack  = (w >= 0) ? 4'(1 << w) : 4'h0;
      exp_busy = (cyc == m_sel_at) || (m_conv_from >= 0 && cyc > m_conv_from && cyc <= m_conv_from + 15);
      checkOutput("cmp_ack", 32'(bus.src_ack), 32'(exp_ack));
      checkOutput("cmp_busy", 32'(busy), 32'(exp_busy));
      checkOutput("cmp_cur_src", 32'(cur_src), 32'(m_cur));
      checkOutput("cmp_digits", 32'({digit3, digit2, digit1, digit0}), 32'(m_dig));

      if (cyc == m_sel_at) begin
        m_sel_at = -1;
        if (w >= 0) begin
          m_ptr = w; m_pend_cur = w; m_cur_at = cyc + 1;
          m_pend_dig = modelDigits(int'(bus.src_value[14*w +: 14]));
`ifdef SEG7_SRC_TAG_EN
          m_pend_dig[19:15] = {1'b0, 4'(w)};
`endif
          m_upd_at = cyc + 16; m_conv_from = cyc; m_term_at = cyc + 15 + (1 << DW);
        end else begin
          m_idle = 1'b1;
        end
      end else if (cyc == m_term_at) begin
        if (freeze) m_term_at = cyc + (1 << DW);
        else if (|bus.src_valid) m_sel_at = cyc + 1;
        else m_idle = 1'b1;
      end else if (m_idle && |bus.src_valid && !freeze) begin
        m_sel_at = cyc + 1;
        m_idle = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] valid, input logic [55:0] values, input logic frz);
    bus.src_valid = valid;
    bus.src_value = values;
    freeze        = frz;
  endtask

  task automatic waitAck(output int t, output logic [3:0] a);
    t = -1000; a = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.src_ack != 0) begin
        t = cyc; a = bus.src_ack;
        return;
      end
    end
    checkOutput("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic waitCycle(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulseResetAndRelease(input logic [3:0] valid, input logic [55:0] values);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(valid, values, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int          t, t_prev, nacks;
  logic [3:0]  a;
  int          bvals[5];
  logic [19:0] blits[5];
  int          rr_order[5];

  initial begin
    bvals = '{1234, 0, 9999, 10000, 16383};
`ifdef SEG7_SRC_TAG_EN
    blits = '{{5'h00, 5'h10, 5'h10, 5'h10}, {5'h00, 5'h00, 5'h00, 5'h00}, {5'h00, 5'h10, 5'h10, 5'h10},
              {5'h00, 5'h10, 5'h10, 5'h10}, {5'h00, 5'h10, 5'h10, 5'h10}};
`else
    blits = '{{5'h01, 5'h02, 5'h03, 5'h04}, {5'h00, 5'h00, 5'h00, 5'h00}, {5'h09, 5'h09, 5'h09, 5'h09},
              {5'h10, 5'h10, 5'h10, 5'h10}, {5'h10, 5'h10, 5'h10, 5'h10}};
`endif
    rst = 1'b1;
    applyStimulus(4'b0000, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_digits", 32'({digit3, digit2, digit1, digit0}), 32'({4{5'h10}}));
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_ack", 32'(bus.src_ack), 32'h0);
    checkOutput("reset_cur_src", 32'(cur_src), 32'h0);
    rst = 1'b0;

    // Single source, value table walked one refresh at a time.
    applyStimulus(4'b0001, pack4(bvals[0], 0, 0, 0), 1'b0);
    waitAck(t, a);
    checkOutput("single_ack", 32'(a), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k < 4) bus.src_value = pack4(bvals[k+1], 0, 0, 0);
      waitCycle(t + 16);
      checkOutput($sformatf("bound_digits_%0d", bvals[k]), 32'({digit3, digit2, digit1, digit0}), 32'(blits[k]));
      t_prev = t;
      waitAck(t, a);
      checkOutput("single_period", 32'(t - t_prev), 32'(PERIOD));
    end

    // Round-robin, all valid.
    rr_order = '{0, 1, 2, 3, 0};
    pulseResetAndRelease(4'b1111, pack4(1, 2, 3, 4));
    for (int k = 0; k < 5; k++) begin
      t_prev = t;
      waitAck(t, a);
      checkOutput($sformatf("rr_ack_%0d", k), 32'(a), 32'(1 << rr_order[k]));
      if (k > 0) checkOutput("rr_period", 32'(t - t_prev), 32'(PERIOD));
    end

    // Round-robin with sources 0 and 2 only.
    rr_order = '{0, 2, 0, 0, 0};
    pulseResetAndRelease(4'b0101, pack4(11, 22, 33, 44));
    for (int k = 0; k < 3; k++) begin
      waitAck(t, a);
      checkOutput($sformatf("rr2_ack_%0d", k), 32'(a), 32'(1 << rr_order[k]));
    end

    // Freeze across three dwell expiries.
    waitCycle(t + 19);
    @(posedge clk); #1;
    freeze = 1'b1;
    nacks = 0;
    while (cyc < t + 68) begin
      @(negedge clk);
      if (bus.src_ack != 0) nacks++;
    end
    checkOutput("freeze_no_ack", 32'(nacks), 32'h0);
    @(posedge clk); #1;
    freeze = 1'b0;
    t_prev = t;
    waitAck(t, a);
    checkOutput("unfreeze_ack", 32'(a), 32'h4);
    checkOutput("unfreeze_delay", 32'(t - t_prev), 32'(16 + 4 * (1 << DW)));

    // Reset during conversion step 7.
    while (cyc < t + 8) @(posedge clk);
    #2;
    checkOutput("pre_abort_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("abort_digits", 32'({digit3, digit2, digit1, digit0}), 32'({4{5'h10}}));
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_ack", 32'(bus.src_ack), 32'h0);
    applyStimulus(4'b1111, pack4(5, 6, 7, 8), 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    waitAck(t, a);
    checkOutput("abort_first_ack", 32'(a), 32'h1);

    // Source 2 alone with value 512.
    pulseResetAndRelease(4'b0100, pack4(0, 0, 512, 0));
    waitAck(t, a);
    checkOutput("tag_ack", 32'(a), 32'h4);
    waitCycle(t + 16);
`ifdef SEG7_SRC_TAG_EN
    checkOutput("tag_digits", 32'({digit3, digit2, digit1, digit0}), 32'({5'h02, 5'h05, 5'h01, 5'h02}));
`else
    checkOutput("tag_digits", 32'({digit3, digit2, digit1, digit0}), 32'({5'h00, 5'h05, 5'h01, 5'h02}));
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
